// File: rtl/fetch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fetch_arbiter_pkg
//   Shared definitions for the instruction-fetch arbiter: FSM state encoding,
//   default geometry, and the instruction/data address-region boundaries.
//   No ports (package).
// -----------------------------------------------------------------------------
package fetch_arbiter_pkg;

  // Default geometry; the top-level parameters fall back to these.
  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_MEM_LAT   = 1;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_INST_W    = 64;

  // Latency counter width: large enough for the longest supported latency (7).
  localparam int CNT_W = 3;

  // Address map for the default width: instructions live in the lower half,
  // the upper half (MSB set) is the data region.
  localparam logic [DEF_ADDR_W-1:0] INST_MEM_START = '0;
  localparam logic [DEF_ADDR_W-1:0] DATA_MEM_START = {1'b1, {(DEF_ADDR_W-1){1'b0}}};

  // Transaction FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage : fetch_arbiter_pkg

// File: rtl/fetch_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
//   Combinational round-robin selector. Requesters above the last winner are
//   preferred; if none of them is requesting, the lowest requesting index wins
//   (wrap-around). Result is a one-hot grant plus its binary index.
//
// Ports
//   req_i          [NUM_CORES-1:0]  request vector
//   last_winner_i  [IDX_W-1:0]      index of the previous winner
//   gnt_o          [NUM_CORES-1:0]  one-hot selection (all-zero if no request)
//   idx_o          [IDX_W-1:0]      binary index of the selection
//   any_o                           at least one request is present
// -----------------------------------------------------------------------------
module rr_select #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [IDX_W-1:0]     last_winner_i,
  output logic [NUM_CORES-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  logic [NUM_CORES-1:0] upper_mask;
  logic [NUM_CORES-1:0] masked_req;
  logic [NUM_CORES-1:0] pick_src;

  // Bits strictly above the last winner form the preferred search window.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      upper_mask[i] = (IDX_W'(i) > last_winner_i);
    end
  end

  assign masked_req = req_i & upper_mask;
  assign pick_src   = (|masked_req) ? masked_req : req_i;
  assign any_o      = |req_i;

  // Fixed priority on the chosen window: scanning downwards lets the lowest
  // set bit overwrite any higher one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the no-request path infers a latch.
    gnt_o = '0;
    idx_o = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule : rr_select

// File: rtl/fetch_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_arbiter
//   Shares one instruction-memory read port between NUM_CORES fetch units.
//   One transaction at a time: IDLE (arbitrate) -> ISSUE (read strobe) ->
//   WAIT (MEM_LAT cycles) -> DONE (deliver) -> IDLE.
//
// Optional feature (macro FETCH_ARB_BOUND_CHK_EN):
//   A latched address in the data region (MSB set) is never sent to memory;
//   the transaction completes with inst_out = 0 and the sticky bound_err
//   output is raised until reset. Without the macro the port is absent and
//   every address is issued unchecked.
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   req         [NUM_CORES]          per-core fetch request (level)
//   req_addr    [NUM_CORES*ADDR_W]   per-core address, core i at [i*ADDR_W +: ADDR_W]
//   grant       [NUM_CORES]          one-hot owner, ISSUE..DONE
//   inst_valid  [NUM_CORES]          one-cycle delivery pulse to the owner
//   inst_out    [INST_W]             fetched word, broadcast
//   busy                             transaction in flight, ISSUE..DONE
//   mem_rd                           memory read strobe (ISSUE only)
//   mem_addr    [ADDR_W]             memory read address
//   bound_err                        sticky data-region error (macro only)
//   mem_rdata   [INST_W]             read data, valid MEM_LAT cycles after mem_rd
// -----------------------------------------------------------------------------
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int MEM_LAT   = DEF_MEM_LAT,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int INST_W    = DEF_INST_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        grant,
  output logic [NUM_CORES-1:0]        inst_valid,
  output logic [INST_W-1:0]           inst_out,
  output logic                        busy,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
`ifdef FETCH_ARB_BOUND_CHK_EN
  output logic                        bound_err,
`endif
  input  logic [INST_W-1:0]           mem_rdata
);

  localparam int IDX_W = $clog2(NUM_CORES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_e         state_q;
  logic [IDX_W-1:0]     winner_q;
  logic [IDX_W-1:0]     last_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_CORES-1:0] grant_q;
  logic [NUM_CORES-1:0] valid_q;
  logic [INST_W-1:0]    inst_q;
  logic                 busy_q;
  logic                 mem_rd_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_CORES-1:0] rr_gnt;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_any;
  logic [ADDR_W-1:0]    win_addr;

  rr_select #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req_i         (req),
    .last_winner_i (last_q),
    .gnt_o         (rr_gnt),
    .idx_o         (rr_idx),
    .any_o         (rr_any)
  );

  assign win_addr = req_addr[rr_idx*ADDR_W +: ADDR_W];

  // ---------------------------------------------------------------------------
  // Data-region check. win_bad suppresses the read strobe as the address is
  // latched; cur_bad diverts the latched transaction from WAIT to DONE.
  // ---------------------------------------------------------------------------
  logic win_bad;
  logic cur_bad;

`ifdef FETCH_ARB_BOUND_CHK_EN
  logic bound_err_q;

  assign win_bad = win_addr[ADDR_W-1];
  assign cur_bad = addr_q[ADDR_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bound_err_q <= 1'b0;
    end else if (state_q == ISSUE && cur_bad) begin
      bound_err_q <= 1'b1;
    end
  end

  assign bound_err = bound_err_q;
`else
  assign win_bad = 1'b0;
  assign cur_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Transaction FSM, all outputs registered.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      winner_q <= '0;
      last_q   <= IDX_W'(NUM_CORES - 1);
      addr_q   <= ADDR_W'(INST_MEM_START);
      cnt_q    <= '0;
      grant_q  <= '0;
      valid_q  <= '0;
      inst_q   <= '0;
      busy_q   <= 1'b0;
      mem_rd_q <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to zero unless re-asserted below.
      valid_q  <= '0;
      mem_rd_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (rr_any) begin
            winner_q <= rr_idx;
            addr_q   <= win_addr;
            grant_q  <= rr_gnt;
            busy_q   <= 1'b1;
            mem_rd_q <= !win_bad;
            state_q  <= ISSUE;
          end
        end

        ISSUE: begin
          if (cur_bad) begin
            // No read went out; complete immediately with a zero word.
            inst_q  <= '0;
            valid_q <= grant_q & req;
            state_q <= DONE;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= WAIT;
          end
        end

        WAIT: begin
          if (cnt_q == '0) begin
            inst_q  <= mem_rdata;
            // A winner that dropped its request gets no pulse, but the word
            // is still captured and the pointer still advances in DONE.
            valid_q <= grant_q & req;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        DONE: begin
          last_q  <= winner_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign inst_valid = valid_q;
  assign inst_out   = inst_q;
  assign busy       = busy_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = addr_q;

endmodule : fetch_arbiter

// File: tb/tb_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fetch_arbiter
//   Self-checking bench for fetch_arbiter. Main instance uses MEM_LAT=1 and is
//   compared every cycle against a transaction-level reference model; a second
//   instance with MEM_LAT=3 covers the longer-latency timing. Honours the
//   FETCH_ARB_BOUND_CHK_EN macro when the design is built with it.
// -----------------------------------------------------------------------------
module tb_fetch_arbiter;

  localparam int NC   = 4;
  localparam int AW   = 10;
  localparam int IW   = 64;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
`ifdef FETCH_ARB_BOUND_CHK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Main DUT (MEM_LAT = 1)
  logic [NC-1:0]    req;
  logic [NC*AW-1:0] req_addr;
  logic [NC-1:0]    grant, inst_valid;
  logic [IW-1:0]    inst_out, mem_rdata;
  logic             busy, mem_rd;
  logic [AW-1:0]    mem_addr;

  // Second DUT (MEM_LAT = 3)
  logic [NC-1:0]    req3;
  logic [NC*AW-1:0] req_addr3;
  logic [NC-1:0]    grant3, valid3;
  logic [IW-1:0]    out3, rdata3;
  logic             busy3, rd3;
  logic [AW-1:0]    addr3;

`ifdef FETCH_ARB_BOUND_CHK_EN
  logic berr, berr3;
`endif

  fetch_arbiter #(.NUM_CORES(NC), .MEM_LAT(LAT), .ADDR_W(AW), .INST_W(IW)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_addr   (req_addr),
    .grant      (grant),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .busy       (busy),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
`ifdef FETCH_ARB_BOUND_CHK_EN
    .bound_err  (berr),
`endif
    .mem_rdata  (mem_rdata)
  );

  fetch_arbiter #(.NUM_CORES(NC), .MEM_LAT(LAT3), .ADDR_W(AW), .INST_W(IW)) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req3),
    .req_addr   (req_addr3),
    .grant      (grant3),
    .inst_valid (valid3),
    .inst_out   (out3),
    .busy       (busy3),
    .mem_rd     (rd3),
    .mem_addr   (addr3),
`ifdef FETCH_ARB_BOUND_CHK_EN
    .bound_err  (berr3),
`endif
    .mem_rdata  (rdata3)
  );

  // ---------------------------------------------------------------------------
  // Instruction memory: data appears exactly LAT cycles after the strobe,
  // random junk at any other time so early/late capture is visible.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] mem [1024];
  logic [IW-1:0] junk;
  logic          p1_v;
  logic [AW-1:0] p1_a;
  logic          p3_v [LAT3];
  logic [AW-1:0] p3_a [LAT3];

  always @(posedge clk) begin
    junk    <= {$urandom, $urandom};
    p1_v    <= mem_rd;
    p1_a    <= mem_addr;
    p3_v[0] <= rd3;
    p3_a[0] <= addr3;
    for (int i = 1; i < LAT3; i++) begin
      p3_v[i] <= p3_v[i-1];
      p3_a[i] <= p3_a[i-1];
    end
  end

  assign mem_rdata = p1_v ? mem[p1_a] : junk;
  assign rdata3    = p3_v[LAT3-1] ? mem[p3_a[LAT3-1]] : junk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a transaction is a timeline of offsets from the arbitration
  // edge. Offset 1 = read strobe, offset LAT+2 = delivery (2 when the address
  // is rejected), one more cycle returns to idle.
  // ---------------------------------------------------------------------------
  bit            m_act, m_bad;
  int            m_k, m_w, m_last;
  logic [AW-1:0] m_addr;
  logic [NC-1:0] e_grant, e_valid;
  logic [IW-1:0] e_out;
  logic          e_busy, e_rd, e_berr;
  logic [AW-1:0] e_addr;

  function automatic int rr_pick(input logic [NC-1:0] r, input int last);
    for (int k = 1; k <= NC; k++) begin
      if (r[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_act = 0; m_bad = 0; m_k = 0; m_w = 0; m_last = NC - 1; m_addr = '0;
    e_grant = '0; e_valid = '0; e_out = '0; e_busy = 0; e_rd = 0; e_berr = 0; e_addr = '0;
  endtask

  // Called at a rising edge with the inputs that were present before it.
  task automatic model_step();
    int total;
    e_rd    = 1'b0;
    e_valid = '0;
    if (!m_act) begin
      if (req != '0) begin
        m_w       = rr_pick(req, m_last);
        m_addr    = req_addr[m_w*AW +: AW];
        m_bad     = BCHK && m_addr[AW-1];
        m_act     = 1;
        m_k       = 1;
        e_grant   = '0;
        e_grant[m_w] = 1'b1;
        e_busy    = 1'b1;
        e_rd      = !m_bad;
        e_addr    = m_addr;
      end
    end else begin
      m_k++;
      total = m_bad ? 2 : LAT + 2;
      if (m_k == total) begin
        if (req[m_w]) e_valid[m_w] = 1'b1;
        e_out = m_bad ? '0 : mem[m_addr];
        if (m_bad) e_berr = 1'b1;
      end else if (m_k == total + 1) begin
        m_act   = 0;
        m_last  = m_w;
        e_grant = '0;
        e_busy  = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("grant",      64'(grant),      64'(e_grant));
    chk("inst_valid", 64'(inst_valid), 64'(e_valid));
    chk("inst_out",   inst_out,        e_out);
    chk("busy",       64'(busy),       64'(e_busy));
    chk("mem_rd",     64'(mem_rd),     64'(e_rd));
    chk("mem_addr",   64'(mem_addr),   64'(e_addr));
`ifdef FETCH_ARB_BOUND_CHK_EN
    chk("bound_err",  64'(berr),       64'(e_berr));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Reset asserted away from the clock edge; outputs must clear without a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  int p_idx [5];
  int p_cyc [5];
  int n_p, rd_cnt, v_cyc;
  bit seen;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    mem[5] = 64'hA5;

    reset_n = 1'b0; req = '0; req_addr = '0; req3 = '0; req_addr3 = '0;
    #2;
    model_reset();
    check_all();
    chk("rst3_grant", 64'(grant3), 64'(0));
    chk("rst3_out",   out3,        64'(0));
    chk("rst3_rd",    64'(rd3),    64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Single request, core 0, address 5.
    req = 4'b0001; req_addr[0 +: AW] = 10'd5;
    tick(); chk("single_rd_c1", 64'(mem_rd), 64'(1)); chk("single_addr_c1", 64'(mem_addr), 64'(5));
    tick(); chk("single_rd_c2", 64'(mem_rd), 64'(0));
    tick(); chk("single_valid_c3", 64'(inst_valid), 64'(4'b0001)); chk("single_data_c3", inst_out, 64'hA5);
    req = '0;
    tick(); chk("single_busy_c4", 64'(busy), 64'(0));

    // All cores request continuously from a fresh pointer.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NC; i++) req_addr[i*AW +: AW] = AW'(10 * (i + 1));
    for (int i = 0; i < 5; i++) begin p_idx[i] = -1; p_cyc[i] = -1; end
    n_p = 0;
    for (int c = 1; c <= 40 && n_p < 5; c++) begin
      tick();
      if (inst_valid != '0) begin
        p_idx[n_p] = onehot_idx(inst_valid);
        p_cyc[n_p] = c;
        n_p++;
      end
    end
    req = '0;
    chk("rr_pulses", 64'(n_p), 64'(5));
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(p_idx[i]), 64'(i % NC));
    chk("rr_first_cycle", 64'(p_cyc[0]), 64'(LAT + 2));
    for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(p_cyc[i] - p_cyc[i-1]), 64'(LAT + 3));
    tick();

    // Core 1 drops its request during WAIT; core 2 is waiting behind it.
    req = 4'b0110; req_addr[1*AW +: AW] = 10'd100; req_addr[2*AW +: AW] = 10'd200;
    tick(); chk("drop_grant_c1", 64'(grant), 64'(4'b0010));
    tick();
    req[1] = 1'b0;
    tick(); chk("drop_valid_c3", 64'(inst_valid), 64'(0));
            chk("drop_busy_c3", 64'(busy), 64'(1));
            chk("drop_data_c3", inst_out, mem[100]);
    tick(); chk("drop_busy_c4", 64'(busy), 64'(0));
    tick(); chk("drop_next_grant", 64'(grant), 64'(4'b0100));
    tick(); tick(); chk("drop_core2_valid", 64'(inst_valid), 64'(4'b0100));

    // Pointer now at core 2: 1010 would go to core 3. Reset during WAIT must
    // abort and restart arbitration at core 0, so core 1 wins afterwards.
    req = 4'b1010; req_addr[1*AW +: AW] = 10'd150; req_addr[3*AW +: AW] = 10'd300;
    tick();
    tick(); chk("pre_rst_grant", 64'(grant), 64'(4'b1000));
    tick();
    do_reset();
    chk("rst_busy_async", 64'(busy), 64'(0));
    tick(); chk("post_rst_grant", 64'(grant), 64'(4'b0010));
    tick(); tick(); chk("post_rst_valid", 64'(inst_valid), 64'(4'b0010));
    req[1] = 1'b0;
    seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      if (inst_valid[3]) seen = 1;
    end
    req = '0;
    chk("post_rst_core3_served", 64'(seen), 64'(1));
    tick();

    // Longer latency instance, core 2 alone.
    req3 = 4'b0100; req_addr3[2*AW +: AW] = 10'd77;
    rd_cnt = 0; v_cyc = -1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (rd3) rd_cnt++;
      if (c == 1) begin
        chk("lat3_grant_c1", 64'(grant3), 64'(4'b0100));
        chk("lat3_addr_c1",  64'(addr3),  64'(77));
      end
      if (valid3 != '0 && v_cyc < 0) begin
        v_cyc = c;
        chk("lat3_valid_vec", 64'(valid3), 64'(4'b0100));
        chk("lat3_data", out3, mem[77]);
        req3 = '0;
      end
      if (c == 6) chk("lat3_busy_c6", 64'(busy3), 64'(0));
    end
    chk("lat3_valid_cycle", 64'(v_cyc), 64'(5));
    chk("lat3_rd_count", 64'(rd_cnt), 64'(1));

`ifdef FETCH_ARB_BOUND_CHK_EN
    // Data-region address: no read, early zero delivery, sticky error.
    req = 4'b1000; req_addr[3*AW +: AW] = 10'd600;
    tick(); chk("bchk_no_rd", 64'(mem_rd), 64'(0));
    tick(); chk("bchk_valid_c2", 64'(inst_valid), 64'(4'b1000));
            chk("bchk_zero", inst_out, 64'(0));
            chk("bchk_err", 64'(berr), 64'(1));
    req = '0;
    for (int c = 0; c < 5; c++) tick();
    chk("bchk_err_sticky", 64'(berr), 64'(1));
    do_reset();
    chk("bchk_err_cleared", 64'(berr), 64'(0));
`endif

    // Random traffic: each core holds its request until served, then may
    // re-request later with a new address.
    req = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (req[i] && inst_valid[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'(BCHK ? $urandom_range(0, 1023) : $urandom_range(0, 511));
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_arbiter

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4, number of fetch requesters (2..8).
REQ-002 Parameter MEM_LAT, default 1, instruction-memory read latency in cycles (1..7).
REQ-003 Parameter ADDR_W, default 10, instruction-memory address width.
REQ-004 Parameter INST_W, default 64, fetched-word width, matching the pipeline datapath width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_CORES  per-core fetch request, level.
REQ-008 req_addr  in  NUM_CORES*ADDR_W  per-core fetch address; core i at bits [i*ADDR_W +: ADDR_W].
REQ-009 grant  out  NUM_CORES  one-hot, current transaction owner.
REQ-010 inst_valid  out  NUM_CORES  one-cycle pulse per core; doubles as fetch/decode register enable.
REQ-011 inst_out  out  INST_W  fetched word, broadcast to all cores; valid only with inst_valid.
REQ-012 busy  out  1  transaction in flight.
REQ-013 mem_rd  out  1  memory read strobe.
REQ-014 mem_addr  out  ADDR_W  memory read address.
REQ-015 mem_rdata  in  INST_W  memory read data, valid MEM_LAT cycles after mem_rd.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: if any req bit set, select winner by round-robin, latch winner index and its req_addr, go to ISSUE; otherwise stay in IDLE.
REQ-018 Round-robin: search starts at (last_winner+1) mod NUM_CORES; after reset last_winner = NUM_CORES-1, so core 0 has first priority.
REQ-019 ISSUE: mem_rd=1 for exactly one cycle with latched mem_addr; load latency counter with MEM_LAT-1; go to WAIT.
REQ-020 WAIT: decrement counter each cycle; on counter==0 capture mem_rdata into inst_out and go to DONE.
REQ-021 DONE: inst_valid[winner]=1 for one cycle; update last_winner; go to IDLE.
REQ-022 Latency: req at cycle 0 in IDLE gives inst_valid at cycle MEM_LAT+2.
REQ-023 grant and busy SHALL be asserted from ISSUE through DONE inclusive, and deasserted in IDLE.
REQ-024 A requester SHALL hold req and req_addr stable until its inst_valid pulse.
REQ-025 If the winner drops req before DONE, the memory read still completes, inst_out updates, inst_valid is suppressed, and the round-robin pointer still advances.
REQ-026 Requests arriving mid-transaction wait; they are never lost while held.
REQ-027 At most one transaction SHALL be outstanding; mem_rd SHALL never be asserted outside ISSUE.

Reset
REQ-028 While reset_n=0: state=IDLE, grant=0, inst_valid=0, inst_out=0, busy=0, mem_rd=0, mem_addr=0, counter=0, last_winner=NUM_CORES-1.
REQ-029 Reset mid-transaction aborts it: no inst_valid is produced, and the first request after release is re-arbitrated from core 0.

Configuration
REQ-030 Macro FETCH_ARB_BOUND_CHK_EN: when defined, a latched address with bit ADDR_W-1 set (data region, 512 and up for ADDR_W=10) skips ISSUE/WAIT and goes straight to DONE with inst_out=0.
REQ-031 With FETCH_ARB_BOUND_CHK_EN defined, a sticky output bound_err (1 bit) SHALL be set, and cleared only by reset.
REQ-032 Without FETCH_ARB_BOUND_CHK_EN: the bound_err port SHALL be absent, and every address is issued to memory unchecked.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the INST_MEM_START/DATA_MEM_START constants and the default widths.
REQ-034 The round-robin selector SHALL be one sub-module, rr_select (combinational mask-and-priority, inputs req and last_winner, output one-hot plus index).

Verification
REQ-035 Single request: req=4'b0001, req_addr[0]=10'd5, mem[5]=64'hA5, MEM_LAT=1 -> mem_rd at cycle 1 with mem_addr=5, inst_valid=4'b0001 and inst_out=64'hA5 at cycle 3.
REQ-036 All four cores request continuously -> grant order 0,1,2,3,0, with one inst_valid pulse every MEM_LAT+3 cycles.
REQ-037 MEM_LAT=3, core 2 alone -> inst_valid[2] at cycle 5, and mem_rd high for exactly one cycle.
REQ-038 Core 1 drops req during WAIT -> no inst_valid[1], busy falls after DONE, and the next grant goes to core 2 if it is requesting.
REQ-039 reset_n pulsed low during WAIT -> all outputs zero asynchronously; after release, req=4'b1010 gives a first grant to core 1.
REQ-040 FETCH_ARB_BOUND_CHK_EN defined, req_addr[3]=10'd600 -> no mem_rd, inst_valid[3] at cycle 2 with inst_out=0, and bound_err=1 held until reset.
